// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit
//   Clocked, byte-addressed, little-endian instruction store that sits between
//   the PC/fetch stage and decode. Program bytes are written through a
//   byte-wide load port. Fetches use a valid/ready request/response handshake
//   with a single registered response slot. The read latency is one cycle.
//   Misaligned or out-of-range fetches return a NOP with the fault flag set.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   ld_en        program-load byte write strobe (has priority over fetches)
//   ld_addr      program-load byte address
//   ld_data      program-load byte
//   req_valid    fetch request valid
//   req_addr     fetch byte address (PC)
//   req_ready    unit accepts a fetch this cycle
//   resp_valid   Instruction/fault/fault_addr hold a response
//   resp_ready   consumer takes the response
//   Instruction  fetched word {mem[a+3],mem[a+2],mem[a+1],mem[a]}
//   fault        response is a misaligned or out-of-range fetch
//   fault_addr   request address of the held response
//   fetch_count  accepted fetches since reset (wraps)
module imem_fetch_unit #(
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned ALIGN_CHECK = 1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       Instruction,
  output logic              fault,
  output logic [ADDR_W-1:0] fault_addr,
  output logic [CNT_W-1:0]  fetch_count
);

  localparam int unsigned       IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 4);
  localparam logic [31:0]       NOP       = 32'h0000_0013;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [7:0]       mem [DEPTH];
  logic             accept;
  logic             misaligned;
  logic             out_of_range;
  logic             req_fault;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rd_word;

  // Storage has no reset: program contents survive a core reset.
  // Addresses are range-checked at full width so high bits never alias.
  always_ff @(posedge clk) begin
    if (ld_en && (ld_addr < DEPTH_A)) begin
      mem[ld_addr[IDX_W-1:0]] <= ld_data;
    end
  end

  // The word read is only used when the address is in range; on a fault the
  // NOP is substituted, so out-of-range indices here never reach the output.
  always_comb begin
    idx          = req_addr[IDX_W-1:0];
    rd_word      = {mem[idx + IDX_W'(3)], mem[idx + IDX_W'(2)],
                    mem[idx + IDX_W'(1)], mem[idx]};
    misaligned   = (ALIGN_CHECK != 0) && (req_addr[1:0] != 2'b00);
    out_of_range = (req_addr > LAST_WORD);
    req_fault    = misaligned || out_of_range;
  end

  // Next-state and handshake signals.
  always_comb begin
    state_d    = state_q;
    req_ready  = !ld_en && ((state_q == EMPTY) || resp_ready);
    accept     = req_valid && req_ready;
    resp_valid = (state_q == FULL);
    if (accept) begin
      state_d = FULL;
    end else if ((state_q == FULL) && resp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Response payload: only updated on accept, so it holds while stalled and
  // keeps its last value after the response retires.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Instruction <= '0;
      fault       <= 1'b0;
      fault_addr  <= '0;
      fetch_count <= '0;
    end else if (accept) begin
      Instruction <= req_fault ? NOP : rd_word;
      fault       <= req_fault;
      fault_addr  <= req_addr;
      fetch_count <= fetch_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed testbench for imem_fetch_unit (default parameters: DEPTH=256,
// ADDR_W=64, ALIGN_CHECK=1). Inputs change 1 time unit after a rising edge
// and outputs are sampled at that point too.
module tb_imem_fetch_unit;

  logic        clk;
  logic        reset;
  logic        ld_en;
  logic [63:0] ld_addr;
  logic [7:0]  ld_data;
  logic        req_valid;
  logic [63:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] Instruction;
  logic        fault;
  logic [63:0] fault_addr;
  logic [31:0] fetch_count;

  int checks   = 0;
  int failures = 0;

  imem_fetch_unit #(
    .ADDR_W     (64),
    .DEPTH      (256),
    .ALIGN_CHECK(1),
    .CNT_W      (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .Instruction(Instruction),
    .fault      (fault),
    .fault_addr (fault_addr),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [63:0] a, input logic [7:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_en   = 1'b0;
  endtask

  // Single fetch with resp_ready=1, leaves the unit FULL with the response.
  task automatic fetch_one(input logic [63:0] a);
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_addr   = a;
    tick();
    req_valid  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
    tick(); tick();
    checks++; if (resp_valid !== 1'b0) begin $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); failures++; end
    checks++; if (Instruction !== 32'h0) begin $display("FAIL reset_instr got=%h exp=00000000", Instruction); failures++; end
    checks++; if (fault !== 1'b0 || fault_addr !== 64'h0) begin $display("FAIL reset_fault got=%b/%h exp=0/0", fault, fault_addr); failures++; end
    checks++; if (fetch_count !== 32'd0) begin $display("FAIL reset_count got=%0d exp=0", fetch_count); failures++; end
    reset = 1'b1;
    tick();
    checks++; if (req_ready !== 1'b1) begin $display("FAIL reset_req_ready got=%b exp=1", req_ready); failures++; end
  endtask

  task automatic test_basic_fetch();
    load_byte(64'd0, 8'h83); load_byte(64'd1, 8'h34);
    load_byte(64'd2, 8'h05); load_byte(64'd3, 8'h0F);
    fetch_one(64'd0);
    checks++; if (resp_valid !== 1'b1) begin $display("FAIL basic_resp_valid got=%b exp=1", resp_valid); failures++; end
    checks++; if (Instruction !== 32'h0F053483) begin $display("FAIL basic_instr got=%h exp=0f053483", Instruction); failures++; end
    checks++; if (fault !== 1'b0) begin $display("FAIL basic_fault got=%b exp=0", fault); failures++; end
    checks++; if (fetch_count !== 32'd1) begin $display("FAIL basic_count got=%0d exp=1", fetch_count); failures++; end
    tick();
    checks++; if (resp_valid !== 1'b0) begin $display("FAIL basic_retire got=%b exp=0", resp_valid); failures++; end
    checks++; if (Instruction !== 32'h0F053483) begin $display("FAIL basic_hold_after_retire got=%h exp=0f053483", Instruction); failures++; end
  endtask

  task automatic test_back_to_back();
    load_byte(64'd4, 8'hB3);  load_byte(64'd5, 8'h84);
    load_byte(64'd6, 8'h9A);  load_byte(64'd7, 8'h00);
    load_byte(64'd8, 8'h93);  load_byte(64'd9, 8'h84);
    load_byte(64'd10, 8'h14); load_byte(64'd11, 8'h00);
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 64'd4;
    #1;
    checks++; if (req_ready !== 1'b1) begin $display("FAIL b2b_ready0 got=%b exp=1", req_ready); failures++; end
    tick();
    checks++; if (resp_valid !== 1'b1 || Instruction !== 32'h009A84B3) begin $display("FAIL b2b_first got=%b/%h exp=1/009a84b3", resp_valid, Instruction); failures++; end
    req_addr = 64'd8;
    #1;
    checks++; if (req_ready !== 1'b1) begin $display("FAIL b2b_ready1 got=%b exp=1", req_ready); failures++; end
    tick();
    checks++; if (resp_valid !== 1'b1 || Instruction !== 32'h00148493) begin $display("FAIL b2b_second got=%b/%h exp=1/00148493", resp_valid, Instruction); failures++; end
    checks++; if (fetch_count !== 32'd3) begin $display("FAIL b2b_count got=%0d exp=3", fetch_count); failures++; end
    req_valid = 1'b0;
    tick();
    checks++; if (resp_valid !== 1'b0) begin $display("FAIL b2b_drain got=%b exp=0", resp_valid); failures++; end
  endtask

  task automatic test_backpressure();
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 64'd0;
    tick();
    // Keep a second request pending: it must not be accepted while stalled.
    req_addr = 64'd4;
    for (int i = 0; i < 3; i++) begin
      checks++; if (resp_valid !== 1'b1 || Instruction !== 32'h0F053483) begin $display("FAIL stall_hold[%0d] got=%b/%h exp=1/0f053483", i, resp_valid, Instruction); failures++; end
      checks++; if (req_ready !== 1'b0) begin $display("FAIL stall_ready[%0d] got=%b exp=0", i, req_ready); failures++; end
      tick();
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin $display("FAIL stall_release_ready got=%b exp=1", req_ready); failures++; end
    tick();
    checks++; if (resp_valid !== 1'b0) begin $display("FAIL stall_retire got=%b exp=0", resp_valid); failures++; end
    checks++; if (fetch_count !== 32'd4) begin $display("FAIL stall_count got=%0d exp=4", fetch_count); failures++; end
  endtask

  task automatic test_faults();
    load_byte(64'd252, 8'h01); load_byte(64'd253, 8'h02);
    load_byte(64'd254, 8'h03); load_byte(64'd255, 8'h04);
    fetch_one(64'd2);
    checks++; if (fault !== 1'b1 || Instruction !== 32'h00000013 || fault_addr !== 64'd2) begin $display("FAIL misalign got=%b/%h/%h exp=1/00000013/2", fault, Instruction, fault_addr); failures++; end
    fetch_one(64'd252);
    checks++; if (fault !== 1'b0 || Instruction !== 32'h04030201) begin $display("FAIL last_word got=%b/%h exp=0/04030201", fault, Instruction); failures++; end
    fetch_one(64'd254);
    checks++; if (fault !== 1'b1 || Instruction !== 32'h00000013) begin $display("FAIL depth_minus2 got=%b/%h exp=1/00000013", fault, Instruction); failures++; end
    fetch_one(64'd256);
    checks++; if (fault !== 1'b1 || fault_addr !== 64'd256) begin $display("FAIL depth got=%b/%h exp=1/100", fault, fault_addr); failures++; end
    fetch_one(64'h1_0000_0000);
    checks++; if (fault !== 1'b1 || Instruction !== 32'h00000013 || fault_addr !== 64'h1_0000_0000) begin $display("FAIL alias got=%b/%h/%h exp=1/00000013/100000000", fault, Instruction, fault_addr); failures++; end
    checks++; if (fetch_count !== 32'd9) begin $display("FAIL fault_count got=%0d exp=9", fetch_count); failures++; end
    tick();
  endtask

  task automatic test_load_priority();
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 64'd0;
    ld_en      = 1'b1;
    ld_addr    = 64'd0;
    ld_data    = 8'hAA;
    #1;
    checks++; if (req_ready !== 1'b0) begin $display("FAIL load_blocks_ready got=%b exp=0", req_ready); failures++; end
    tick();
    checks++; if (resp_valid !== 1'b0 || fetch_count !== 32'd9) begin $display("FAIL load_blocks_accept got=%b/%0d exp=0/9", resp_valid, fetch_count); failures++; end
    // Out-of-range load must be dropped, not aliased onto byte 0.
    ld_addr = 64'd256;
    ld_data = 8'h55;
    tick();
    ld_en = 1'b0;
    tick();
    req_valid = 1'b0;
    checks++; if (Instruction !== 32'h0F0534AA) begin $display("FAIL load_new_byte got=%h exp=0f0534aa", Instruction); failures++; end
    checks++; if (fetch_count !== 32'd10) begin $display("FAIL load_count got=%0d exp=10", fetch_count); failures++; end
    tick();
  endtask

  task automatic test_load_while_held();
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 64'd0;
    tick();
    req_valid = 1'b0;
    load_byte(64'd0, 8'h83);
    checks++; if (resp_valid !== 1'b1 || Instruction !== 32'h0F0534AA) begin $display("FAIL held_unaltered got=%b/%h exp=1/0f0534aa", resp_valid, Instruction); failures++; end
    resp_ready = 1'b1;
    tick();
    fetch_one(64'd0);
    checks++; if (Instruction !== 32'h0F053483) begin $display("FAIL held_reload got=%h exp=0f053483", Instruction); failures++; end
    tick();
  endtask

  task automatic test_async_reset();
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 64'd4;
    tick();
    req_valid = 1'b0;
    checks++; if (resp_valid !== 1'b1) begin $display("FAIL areset_pre_full got=%b exp=1", resp_valid); failures++; end
    #2 reset = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b0 || fetch_count !== 32'd0) begin $display("FAIL areset_immediate got=%b/%0d exp=0/0", resp_valid, fetch_count); failures++; end
    checks++; if (Instruction !== 32'h0 || fault !== 1'b0 || fault_addr !== 64'h0) begin $display("FAIL areset_payload got=%h/%b/%h exp=0/0/0", Instruction, fault, fault_addr); failures++; end
    @(negedge clk);
    reset = 1'b1;
    tick();
    fetch_one(64'd0);
    checks++; if (resp_valid !== 1'b1 || Instruction !== 32'h0F053483 || fetch_count !== 32'd1) begin $display("FAIL areset_persist got=%b/%h/%0d exp=1/0f053483/1", resp_valid, Instruction, fetch_count); failures++; end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_back_to_back();
    test_backpressure();
    test_faults();
    test_load_priority();
    test_load_while_held();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
